// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO using all DEPTH slots, with programmable almost flags, sticky
// error flags, synchronous flush and a standard or first-word-fall-through read port.
module sync_fifo_prog #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     w_data,
    input  logic                 w_en,
    input  logic                 r_en,
    output logic [WIDTH-1:0]     r_data,
    output logic                 r_valid,
    output logic                 w_full,
    output logic                 r_empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AF_C    = (PTR_WIDTH+1)'(AF_THRESH);
    localparam logic [PTR_WIDTH:0] AE_C    = (PTR_WIDTH+1)'(AE_THRESH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_WIDTH:0] w_ptr_reg, r_ptr_reg;
    logic [PTR_WIDTH:0] count_reg, count_next;
    logic               overflow_reg, underflow_reg;
    logic               rd_ok, wr_ok;

    // Flags decode the registered count only, never the same-cycle requests.
    assign w_full       = (count_reg == DEPTH_C);
    assign r_empty      = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_C);
    assign almost_empty = (count_reg <= AE_C);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    assign rd_ok = r_en & ~r_empty;
    assign wr_ok = w_en & (~w_full | rd_ok);

    always_comb begin
        count_next = count_reg;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_reg     <= '0;
            r_ptr_reg     <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (flush) begin
            w_ptr_reg     <= '0;
            r_ptr_reg     <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_ok)
                w_ptr_reg <= w_ptr_reg + 1'b1;
            if (rd_ok)
                r_ptr_reg <= r_ptr_reg + 1'b1;
            count_reg <= count_next;
            if (w_en & ~wr_ok)
                overflow_reg <= 1'b1;
            if (r_en & r_empty)
                underflow_reg <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush)
            mem[w_ptr_reg[PTR_WIDTH-1:0]] <= w_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown only while non-empty so r_data reads 0 after reset/flush.
            assign r_data  = r_empty ? '0 : mem[r_ptr_reg[PTR_WIDTH-1:0]];
            assign r_valid = ~r_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_data_reg;
            logic             r_valid_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_data_reg  <= '0;
                    r_valid_reg <= 1'b0;
                end else if (flush) begin
                    r_data_reg  <= '0;
                    r_valid_reg <= 1'b0;
                end else begin
                    r_valid_reg <= rd_ok;
                    if (rd_ok)
                        r_data_reg <= mem[r_ptr_reg[PTR_WIDTH-1:0]];
                end
            end

            assign r_data  = r_data_reg;
            assign r_valid = r_valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a standard-read and an FWFT instance share one stimulus
// stream and are checked each cycle against a queue-based model of the FIFO.
module tb_sync_fifo_prog;

    logic       clk, reset, flush, w_en, r_en;
    logic [7:0] w_data;
    logic [7:0] s_r_data, f_r_data;
    logic       s_r_valid, f_r_valid;
    logic       s_w_full, f_w_full, s_r_empty, f_r_empty;
    logic       s_af, f_af, s_ae, f_ae;
    logic [4:0] s_count, f_count;
    logic       s_ovf, f_ovf, s_unf, f_unf;

    sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .PTR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut_s (
        .clk(clk), .reset(reset), .flush(flush), .w_data(w_data), .w_en(w_en), .r_en(r_en),
        .r_data(s_r_data), .r_valid(s_r_valid), .w_full(s_w_full), .r_empty(s_r_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf));

    sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .PTR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_f (
        .clk(clk), .reset(reset), .flush(flush), .w_data(w_data), .w_en(w_en), .r_en(r_en),
        .r_data(f_r_data), .r_valid(f_r_valid), .w_full(f_w_full), .r_empty(f_r_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    // Reference model: contents as a queue, plus sticky flags and the standard read port.
    logic [7:0] q[$];
    bit         m_ovf, m_unf, m_rv;
    logic [7:0] m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rv  = 1'b0;
        m_rd  = 8'h00;
    endtask

    task automatic model_step(input logic we, input logic re, input logic [7:0] wd, input logic fl);
        bit rd_ok, wr_ok;
        rd_ok = re && (q.size() > 0);
        wr_ok = we && ((q.size() < 16) || rd_ok);
        if (fl) begin
            model_clear();
        end else begin
            if (we && !wr_ok) m_ovf = 1'b1;
            if (re && q.size() == 0) m_unf = 1'b1;
            m_rv = rd_ok;
            if (rd_ok) m_rd = q.pop_front();
            if (wr_ok) q.push_back(wd);
        end
    endtask

    task automatic cycle(input logic we, input logic re, input logic [7:0] wd, input logic fl);
        w_en = we; r_en = re; w_data = wd; flush = fl;
        @(posedge clk);
        model_step(we, re, wd, fl);
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0; flush = 1'b0;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("count",     {27'd0, s_count}, q.size());
            chk("w_full",    s_w_full,  q.size() == 16);
            chk("r_empty",   s_r_empty, q.size() == 0);
            chk("af",        s_af,      q.size() >= 14);
            chk("ae",        s_ae,      q.size() <= 2);
            chk("overflow",  s_ovf,     m_ovf);
            chk("underflow", s_unf,     m_unf);
            chk("std_valid", s_r_valid, m_rv);
            chk("std_data",  s_r_data,  m_rd);
            chk("f_count",   {27'd0, f_count}, q.size());
            chk("f_valid",   f_r_valid, q.size() != 0);
            chk("f_data",    f_r_data,  (q.size() != 0) ? q[0] : 8'h00);
            chk("f_ovf",     f_ovf,     m_ovf);
            chk("f_unf",     f_unf,     m_unf);
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, {27'd0, s_count}, 0);
        chk({tag, "_empty"}, s_r_empty, 1);
        chk({tag, "_ae"},    s_ae,      1);
        chk({tag, "_full"},  s_w_full,  0);
        chk({tag, "_af"},    s_af,      0);
        chk({tag, "_ovf"},   s_ovf,     0);
        chk({tag, "_unf"},   s_unf,     0);
        chk({tag, "_rv"},    s_r_valid, 0);
        chk({tag, "_rd"},    s_r_data,  0);
        chk({tag, "_f_rv"},  f_r_valid, 0);
        chk({tag, "_f_rd"},  f_r_data,  0);
        chk({tag, "_f_cnt"}, {27'd0, f_count}, 0);
    endtask

    initial begin
        int pushed, guard, maxc;
        logic we, re;
        logic [7:0] d;

        reset = 1'b1; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; w_data = 8'h00;
        model_clear();
        #1;
        chk_reset_vals("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Fill 0x00..0x0F; almost_full from count 14.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 8'(i), 1'b0);
            chk("fill_af", s_af, (i + 1) >= 14);
        end
        chk("fill_count", {27'd0, s_count}, 16);
        chk("fill_full",  s_w_full, 1);

        // Simultaneous push/pop into a full FIFO is accepted.
        cycle(1'b1, 1'b1, 8'hAA, 1'b0);
        chk("fullrw_data",  s_r_data, 8'h00);
        chk("fullrw_valid", s_r_valid, 1);
        chk("fullrw_count", {27'd0, s_count}, 16);
        chk("fullrw_ovf",   s_ovf, 0);

        cycle(1'b1, 1'b0, 8'h99, 1'b0);
        chk("ovf_set",   s_ovf, 1);
        chk("ovf_count", {27'd0, s_count}, 16);

        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("last_read", s_r_data, 8'hAA);
        chk("drained",   s_r_empty, 1);

        // Empty FIFO with push and pop together: write taken, read rejected.
        cycle(1'b1, 1'b1, 8'h55, 1'b0);
        chk("emptyrw_count", {27'd0, s_count}, 1);
        chk("emptyrw_unf",   s_unf, 1);
        chk("emptyrw_rv",    s_r_valid, 0);
        chk("emptyrw_f_rd",  f_r_data, 8'h55);
        chk("emptyrw_f_rv",  f_r_valid, 1);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);

        // Flush with count 5 and overflow set; flush wins over a same-cycle write.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        chk("pre_flush_count", {27'd0, s_count}, 5);
        chk("pre_flush_ovf",   s_ovf, 1);
        cycle(1'b1, 1'b0, 8'hEE, 1'b1);
        chk("flush_count", {27'd0, s_count}, 0);
        chk("flush_empty", s_r_empty, 1);
        chk("flush_ovf",   s_ovf, 0);
        chk("flush_unf",   s_unf, 0);
        chk("flush_rd",    s_r_data, 0);
        cycle(1'b1, 1'b0, 8'h3C, 1'b0);
        chk("post_flush_f_rd", f_r_data, 8'h3C);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("post_flush_rd", s_r_data, 8'h3C);
        chk("post_flush_rv", s_r_valid, 1);

        // Random stream of 40 accepted writes, crossing the pointer wrap.
        pushed = 0; guard = 0; maxc = 0;
        while (pushed < 40 && guard < 2000) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if (we && ((q.size() < 16) || (re && q.size() > 0))) pushed++;
            cycle(we, re, d, 1'b0);
            if (int'(s_count) > maxc) maxc = int'(s_count);
            guard++;
        end
        chk("stream_pushes", pushed, 40);
        chk("stream_max_le16", maxc <= 16, 1);

        // Asynchronous reset between edges with count 7 and a read in flight.
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("midrst_count", {27'd0, s_count}, 7);
        chk("midrst_rv",    s_r_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        model_clear();
        @(negedge clk);
        #1 reset = 1'b0;
        cycle(1'b1, 1'b0, 8'h77, 1'b0);
        chk("after_rst_f_rd",  f_r_data, 8'h77);
        chk("after_rst_count", {27'd0, s_count}, 1);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It is the same-clock-domain buffering block used between producer and consumer stages that share one clock. Unlike the dual-clock FIFO, it uses all DEPTH entries, so no slot is wasted, and it accepts a write into a full FIFO when a read pops in the same cycle.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 16, number of entries; must be a power of two, ≥ 2
- PTR_WIDTH, 4, log2(DEPTH); pointers are PTR_WIDTH+1 bits wide, with the MSB used as the wrap bit
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH
- FWFT, 0, read mode: 0 = registered standard read, 1 = first-word-fall-through

- clk  input  1  single clock; everything is on the rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of FIFO contents and error flags
- w_data  input  WIDTH  write data
- w_en  input  1  write request
- r_en  input  1  read request (in FWFT mode: pop/acknowledge)
- r_data  output  WIDTH  read data
- r_valid  output  1  r_data holds a valid word (see Operation)
- w_full  output  1  count == DEPTH
- r_empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_THRESH
- almost_empty  output  1  count ≤ AE_THRESH
- count  output  PTR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a write was rejected
- underflow  output  1  sticky: a read was rejected

## Operation
- Storage: DEPTH×WIDTH register array. Write pointer w_ptr and read pointer r_ptr are binary and PTR_WIDTH+1 bits; they wrap naturally from 2·DEPTH−1 to 0. Addressing uses ptr[PTR_WIDTH-1:0].
- rd_ok = r_en & !r_empty.
- wr_ok = w_en & (!w_full | rd_ok). A write into a full FIFO succeeds only when a read is also accepted that cycle.
- On wr_ok: mem[w_ptr] ← w_data, and w_ptr increments.
- On rd_ok: r_ptr increments.
- count update: next = count + wr_ok − rd_ok. If both are accepted, count is unchanged.
- w_full, r_empty, almost_full and almost_empty are combinational decodes of the count register only. They never depend on same-cycle w_en or r_en.
- overflow is set by (w_en & !wr_ok).
- underflow is set by (r_en & r_empty). An empty FIFO with simultaneous w_en & r_en takes the write, rejects the read, and sets underflow.
- Both error flags hold until flush or reset.
- flush has priority over w_en/r_en. It clears w_ptr, r_ptr, count, overflow, underflow and r_valid, and r_data goes to 0. Memory contents are not cleared.
- FWFT=0: on rd_ok, r_data ← mem[r_ptr] and r_valid = 1 for the next cycle only. Otherwise r_valid = 0 and r_data holds its last value.
- FWFT=1: r_data = mem[r_ptr[PTR_WIDTH-1:0]] and r_valid = !r_empty. r_en acknowledges and pops the presented word.
- Reset values: pointers 0, count 0, r_empty 1, almost_empty 1, w_full 0, almost_full 0 (given AF_THRESH > 0), overflow 0, underflow 0, r_valid 0, r_data 0.

## Timing
- Write-to-visible latency is one cycle. A word written at edge N makes count, r_empty and the FWFT r_data reflect it after edge N.
- Standard read latency is one cycle. r_en accepted at edge N gives r_data and r_valid valid after edge N, for one cycle.
- Flags lag the handshake by exactly one edge: they are a registered count decode.
- Asynchronous reset takes effect immediately, mid-transfer. An in-flight standard read is lost, with r_valid 0.
- flush has the same cycle-level effect as reset but is synchronous. It takes effect at the next edge.
- Wrap-around: after 2·DEPTH pushes and pops, the pointers return to 0 with no change to the flags.

## Test plan
- Reset, then push 16 words 0x00..0x0F with FWFT=0 → count 16, w_full=1, almost_full from count 14. A 17th push is rejected: overflow=1, count stays 16.
- Full FIFO, w_en=1 & r_en=1 with w_data=0xAA → read returns 0x00 next cycle, count stays 16, overflow stays 0, and 0xAA is read last.
- Empty FIFO, w_en=1 & r_en=1 with 0x55 → count 1, underflow=1, r_valid=0. With FWFT=1, r_data=0x55 and r_valid=1 after the edge.
- Stream 40 words through with random w_en/r_en → read order matches write order across pointer wrap, count never exceeds 16, and almost_empty asserts for count ≤ 2.
- With count 5 and overflow set, assert flush for one cycle → count 0, r_empty 1, overflow 0, and the next push/pop of 0x3C returns 0x3C.
- Assert reset mid-stream with count 7, between clock edges → all outputs reach reset values immediately, before the next edge.
